// File: rtl/implies_stim_pkg.sv
// Shared types and constants for the implies checker stimulus sequencer.
package implies_stim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET_A,
        SET_B,
        RAND,
        DONE
    } stim_state_e;

    // Truth-table cases indexed by case_idx: (A,B) = (0,0) (0,1) (1,1) (1,0)
    localparam logic [3:0] CASE_A = 4'b1100;
    localparam logic [3:0] CASE_B = 4'b0110;

    localparam logic [7:0] DEFAULT_LFSR_SEED = 8'hA5;

endpackage

// File: rtl/implies_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seed loaded on reset.
module implies_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] q
);

    logic fb;

    assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[6:0], fb};
        end
    end

endmodule

// File: rtl/implies_stim_gen.sv
// Directed (signal_0, signal_1) sequencer for the implies checker stage.
// Optional random tail enabled by IMPLIES_STIM_RAND_EN.
module implies_stim_gen
    import implies_stim_pkg::*;
#(
    parameter int         HOLD_CYCLES = 2,
    parameter int         N_LOOPS     = 1,
    parameter int         RAND_CYCLES = 16,
    parameter logic [7:0] LFSR_SEED   = DEFAULT_LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       signal_0,
    output logic       signal_1,
    output logic       expect_pass,
    output logic [1:0] case_idx,
    output logic       busy,
    output logic       done
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int LW = $clog2(N_LOOPS + 1);

    stim_state_e   state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [LW-1:0] loop_q, loop_d;
    logic [1:0]    case_d, case_inc;
    logic          s0_d, s1_d, busy_d, done_d;
    logic          hold_last, loop_last;

    assign hold_last = (hold_q == HW'(HOLD_CYCLES - 1));
    assign loop_last = (loop_q == LW'(N_LOOPS - 1));
    assign case_inc  = case_idx + 2'd1;

`ifdef IMPLIES_STIM_RAND_EN
    localparam int RW = $clog2(RAND_CYCLES + 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [7:0]    lfsr_q;
    logic          lfsr_en;

    implies_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{LFSR_SEED, RAND_CYCLES[0]};
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        loop_d  = loop_q;
        case_d  = case_idx;
        s0_d    = signal_0;
        s1_d    = signal_1;
        busy_d  = busy;
        done_d  = 1'b0;
`ifdef IMPLIES_STIM_RAND_EN
        rcnt_d  = rcnt_q;
        lfsr_en = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SET_A;
                    hold_d  = '0;
                    loop_d  = '0;
                    case_d  = 2'd0;
                    s0_d    = CASE_A[0];
                    busy_d  = 1'b1;
                end
            end
            SET_A: begin
                if (hold_last) begin
                    state_d = SET_B;
                    hold_d  = '0;
                    s1_d    = CASE_B[case_idx];
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            SET_B: begin
                if (!hold_last) begin
                    hold_d = hold_q + HW'(1);
                end else if (case_idx != 2'd3) begin
                    state_d = SET_A;
                    hold_d  = '0;
                    case_d  = case_inc;
                    s0_d    = CASE_A[case_inc];
                end else if (!loop_last) begin
                    state_d = SET_A;
                    hold_d  = '0;
                    loop_d  = loop_q + LW'(1);
                    case_d  = 2'd0;
                    s0_d    = CASE_A[0];
                end else begin
`ifdef IMPLIES_STIM_RAND_EN
                    state_d = RAND;
                    s0_d    = lfsr_q[0];
                    s1_d    = lfsr_q[1];
                    lfsr_en = 1'b1;
                    rcnt_d  = RW'(1);
`else
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef IMPLIES_STIM_RAND_EN
            RAND: begin
                if (rcnt_q == RW'(RAND_CYCLES)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    s0_d    = lfsr_q[0];
                    s1_d    = lfsr_q[1];
                    lfsr_en = 1'b1;
                    rcnt_d  = rcnt_q + RW'(1);
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            loop_q      <= '0;
            case_idx    <= 2'd0;
            signal_0    <= 1'b0;
            signal_1    <= 1'b0;
            expect_pass <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            loop_q      <= loop_d;
            case_idx    <= case_d;
            signal_0    <= s0_d;
            signal_1    <= s1_d;
            expect_pass <= !s0_d || s1_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_implies_stim_gen.sv
// Bench for implies_stim_gen: two configurations against a timeline model,
// plus literal timing points from the directed truth-table walk.
module tb_implies_stim_gen;

    localparam int H0 = 2;
    localparam int N0 = 1;
    localparam int H1 = 1;
    localparam int N1 = 2;
    localparam int RC = 16;
`ifdef IMPLIES_STIM_RAND_EN
    localparam int RND = RC;
`else
    localparam int RND = 0;
`endif

    logic clk;
    logic rst_n;
    logic start;
    logic chk_en;

    logic       s0 [2];
    logic       s1 [2];
    logic       ep [2];
    logic [1:0] ci [2];
    logic       bz [2];
    logic       dn [2];

    int checks;
    int failures;

    implies_stim_gen #(
        .HOLD_CYCLES (H0),
        .N_LOOPS     (N0),
        .RAND_CYCLES (RC),
        .LFSR_SEED   (8'hA5)
    ) u0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signal_0    (s0[0]),
        .signal_1    (s1[0]),
        .expect_pass (ep[0]),
        .case_idx    (ci[0]),
        .busy        (bz[0]),
        .done        (dn[0])
    );

    implies_stim_gen #(
        .HOLD_CYCLES (H1),
        .N_LOOPS     (N1),
        .RAND_CYCLES (RC),
        .LFSR_SEED   (8'hA5)
    ) u1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signal_0    (s0[1]),
        .signal_1    (s1[1]),
        .expect_pass (ep[1]),
        .case_idx    (ci[1]),
        .busy        (bz[1]),
        .done        (dn[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Model: each run is a timeline indexed by edges since launch.
    int   hold_of [2] = '{H0, H1};
    int   loops_of[2] = '{N0, N1};
    int   tab_a[4]    = '{0, 0, 1, 1};
    int   tab_b[4]    = '{0, 1, 1, 0};

    bit       m_active[2];
    int       m_t[2];
    logic     m_s0[2];
    logic     m_s1[2];
    int       m_case[2];
    logic     m_busy[2];
    logic     m_done[2];
    logic [7:0] m_lfsr[2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            int h, d, c;
            h = hold_of[i];
            d = 8 * h * loops_of[i];
            if (!rst_n) begin
                m_active[i] = 0;
                m_t[i]      = 0;
                m_s0[i]     = 0;
                m_s1[i]     = 0;
                m_case[i]   = 0;
                m_busy[i]   = 0;
                m_done[i]   = 0;
                m_lfsr[i]   = 8'hA5;
            end else begin
                if (m_done[i]) begin
                    m_done[i] = 0;
                end else if (!m_active[i]) begin
                    if (start) begin
                        m_active[i] = 1;
                        m_t[i]      = 0;
                    end
                end else begin
                    m_t[i]++;
                end
                if (m_active[i]) begin
                    if (m_t[i] < d) begin
                        c = (m_t[i] / (2 * h)) % 4;
                        m_case[i] = c;
                        m_s0[i]   = tab_a[c][0];
                        if ((m_t[i] % (2 * h)) >= h)
                            m_s1[i] = tab_b[c][0];
                        m_busy[i] = 1;
                    end else if (m_t[i] < d + RND) begin
                        m_s0[i]   = m_lfsr[i][0];
                        m_s1[i]   = m_lfsr[i][1];
                        m_lfsr[i] = {m_lfsr[i][6:0],
                                     m_lfsr[i][7] ^ m_lfsr[i][5] ^
                                     m_lfsr[i][4] ^ m_lfsr[i][3]};
                    end else begin
                        m_active[i] = 0;
                        m_busy[i]   = 0;
                        m_done[i]   = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d.signal_0", i), 8'(s0[i]), 8'(m_s0[i]));
                check($sformatf("u%0d.signal_1", i), 8'(s1[i]), 8'(m_s1[i]));
                check($sformatf("u%0d.expect_pass", i), 8'(ep[i]),
                      8'(!m_s0[i] || m_s1[i]));
                check($sformatf("u%0d.case_idx", i), 8'(ci[i]), 8'(m_case[i]));
                check($sformatf("u%0d.busy", i), 8'(bz[i]), 8'(m_busy[i]));
                check($sformatf("u%0d.done", i), 8'(dn[i]), 8'(m_done[i]));
            end
        end
    end

    task automatic check_reset_vals(string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_s0"}, 8'(s0[i]), 8'd0);
            check({tag, "_s1"}, 8'(s1[i]), 8'd0);
            check({tag, "_exp"}, 8'(ep[i]), 8'd1);
            check({tag, "_case"}, 8'(ci[i]), 8'd0);
            check({tag, "_busy"}, 8'(bz[i]), 8'd0);
            check({tag, "_done"}, 8'(dn[i]), 8'd0);
        end
    endtask

    // Raise start before edge E0; returns #2 after E0 with start per 'hold'.
    task automatic launch(bit hold);
        @(negedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = hold;
        #1;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #2;
    endtask

    localparam int DN0 = 8 * H0 * N0 + RND;
    localparam int DN1 = 8 * H1 * N1 + RND;

    initial begin
        checks   = 0;
        failures = 0;
        chk_en   = 1'b0;
        start    = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Directed pass, literal timing points.
        launch(1'b0);
        for (int k = 0; k <= DN0 + 1; k++) begin
            if (k > 0) next_edge();
            if (k == 0) check("e0_s0", 8'(s0[0]), 8'd0);
            if (k == 0) check("e0_busy", 8'(bz[0]), 8'd1);
            if (k == 2) check("e2_s01", {6'd0, s0[0], s1[0]}, 8'b00);
            if (k == 6) check("e6_s01", {6'd0, s0[0], s1[0]}, 8'b01);
            if (k == 8) check("e8_case", 8'(ci[0]), 8'd2);
            if (k == 10) check("e10_s01", {6'd0, s0[0], s1[0]}, 8'b11);
            if (k == 13) check("e13_exp", 8'(ep[0]), 8'd1);
            if (k == 14) check("e14_s01", {6'd0, s0[0], s1[0]}, 8'b10);
            if (k == 14) check("e14_exp", 8'(ep[0]), 8'd0);
            if (k == DN0 - 1) check("last_busy", 8'(bz[0]), 8'd1);
            if (k == DN0) check("done_pulse", {6'd0, dn[0], bz[0]}, 8'b10);
            if (k == DN0 + 1) check("done_gone", 8'(dn[0]), 8'd0);
            if (k == 4) check("u1_e4_case", 8'(ci[1]), 8'd2);
            if (k == 8) check("u1_e8_case", 8'(ci[1]), 8'd0);
            if (k == 14) check("u1_e14_case", 8'(ci[1]), 8'd3);
            if (k == DN1) check("u1_done", 8'(dn[1]), 8'd1);
        end
        check("idle_exp_held", 8'(ep[0]), 8'd0);

        // start held high: one sequence per IDLE visit.
        launch(1'b1);
        for (int k = 1; k <= DN0 + 2; k++) begin
            next_edge();
            if (k == DN0 / 2) check("held_no_restart", 8'(ci[0]), 8'd2);
            if (k == DN0) check("held_done", 8'(dn[0]), 8'd1);
            if (k == DN0 + 1) check("held_idle", 8'(bz[0]), 8'd0);
            if (k == DN0 + 2) check("held_relaunch", 8'(bz[0]), 8'd1);
        end
        @(negedge clk);
        #1 start = 1'b0;
        repeat (2 * DN0 + 4) @(posedge clk);

        // Async reset in the middle of case 2, then replay.
        launch(1'b0);
        repeat (9) next_edge();
        check("pre_rst_case", 8'(ci[0]), 8'd2);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        #1 rst_n = 1'b1;
        launch(1'b0);
        check("replay_case", 8'(ci[0]), 8'd0);
        check("replay_busy", 8'(bz[0]), 8'd1);

        // Random start/reset traffic against the model.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            #1 start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 120) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
